// File: rtl/flag_cond_unit_pkg.sv
// Shared definitions for the flag/condition unit: opcodes, flag bit
// positions, branch condition encodings and the opcode-to-write-mask map.
package flag_cond_unit_pkg;

    localparam int unsigned W_DEF   = 16;
    localparam int unsigned OPW_DEF = 4;
    localparam int unsigned FLAG_W  = 3;
    localparam int unsigned CCC_W   = 3;

    // Flag vector layout is {Z,V,N}
    localparam int unsigned Z_IDX = 2;
    localparam int unsigned V_IDX = 1;
    localparam int unsigned N_IDX = 0;

    localparam logic [OPW_DEF-1:0] OP_ADD    = 4'b0000;
    localparam logic [OPW_DEF-1:0] OP_SUB    = 4'b0001;
    localparam logic [OPW_DEF-1:0] OP_XOR    = 4'b0010;
    localparam logic [OPW_DEF-1:0] OP_RED    = 4'b0011;
    localparam logic [OPW_DEF-1:0] OP_SLL    = 4'b0100;
    localparam logic [OPW_DEF-1:0] OP_SRA    = 4'b0101;
    localparam logic [OPW_DEF-1:0] OP_ROR    = 4'b0110;
    localparam logic [OPW_DEF-1:0] OP_PADDSB = 4'b0111;

    localparam logic [CCC_W-1:0] CCC_NEQ  = 3'b000;
    localparam logic [CCC_W-1:0] CCC_EQ   = 3'b001;
    localparam logic [CCC_W-1:0] CCC_GT   = 3'b010;
    localparam logic [CCC_W-1:0] CCC_LT   = 3'b011;
    localparam logic [CCC_W-1:0] CCC_GTE  = 3'b100;
    localparam logic [CCC_W-1:0] CCC_LTE  = 3'b101;
    localparam logic [CCC_W-1:0] CCC_OVFL = 3'b110;
    localparam logic [CCC_W-1:0] CCC_UNC  = 3'b111;

    // Which flags an opcode is allowed to update
    function automatic logic [FLAG_W-1:0] write_mask(input logic [OPW_DEF-1:0] op);
        logic [FLAG_W-1:0] mask;
        mask = '0;
        case (op)
            OP_ADD, OP_SUB:                 mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b100;
            default:                        mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational branch condition evaluator.
//   flags   : {Z,V,N} to test
//   ccc     : condition code
//   taken_c : condition holds
module flag_cond_unit_cond_eval
    import flag_cond_unit_pkg::*;
(
    input  logic [FLAG_W-1:0] flags,
    input  logic [CCC_W-1:0]  ccc,
    output logic              taken_c
);

    logic z;
    logic v;
    logic n;

    assign z = flags[Z_IDX];
    assign v = flags[V_IDX];
    assign n = flags[N_IDX];

    always_comb begin
        taken_c = 1'b0;
        case (ccc)
            CCC_NEQ:  taken_c = ~z;
            CCC_EQ:   taken_c = z;
            CCC_GT:   taken_c = ~z & ~n;
            CCC_LT:   taken_c = n;
            CCC_GTE:  taken_c = z | ~n;
            CCC_LTE:  taken_c = n | z;
            CCC_OVFL: taken_c = v;
            CCC_UNC:  taken_c = 1'b1;
            default:  taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Condition flag unit: captures EX-stage ALU results into a pending
// (speculative) flag update, commits it one edge later unless flushed, and
// resolves branches against committed flags with bypass from in-flight updates.
//   clk, rst           : clock, synchronous active-high reset
//   ex_valid, ex_op    : EX instruction valid and opcode
//   alu_res, alu_ovfl  : saturated ALU result, pre-saturation signed overflow
//   stall, flush       : hold EX (no capture) / squash pending + EX capture
//   br_valid, br_ccc   : branch request and condition code
//   flags              : committed {Z,V,N}
//   br_done, br_taken  : one-cycle resolution pulse and decision
module flag_cond_unit
    import flag_cond_unit_pkg::*;
#(
    parameter int unsigned W   = W_DEF,
    parameter int unsigned OPW = OPW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [OPW-1:0]     ex_op,
    input  logic [W-1:0]       alu_res,
    input  logic               alu_ovfl,
    input  logic               stall,
    input  logic               flush,
    input  logic               br_valid,
    input  logic [CCC_W-1:0]   br_ccc,
    output logic [FLAG_W-1:0]  flags,
    output logic               br_done,
    output logic               br_taken
);

    logic              pend_v;
    logic [FLAG_W-1:0] pend_mask;
    logic [FLAG_W-1:0] pend_val;

    logic [FLAG_W-1:0] ex_mask_c;
    logic [FLAG_W-1:0] ex_val_c;
    logic              ex_cap_c;
    logic              pend_live_c;
    logic [FLAG_W-1:0] eff_flags_c;
    logic              taken_c;

    // EX-stage flag candidates and capture qualifier
    assign ex_mask_c   = write_mask(OPW_DEF'(ex_op));
    assign ex_val_c    = {alu_res == '0, alu_ovfl, alu_res[W-1]};
    assign ex_cap_c    = ex_valid & ~stall & ~flush & (ex_mask_c != '0);
    assign pend_live_c = pend_v & ~flush;

    // Bypass merge: committed, then pending, then EX; youngest wins per bit
    always_comb begin
        eff_flags_c = flags;
        if (pend_live_c) begin
            eff_flags_c = (eff_flags_c & ~pend_mask) | (pend_val & pend_mask);
        end
        if (ex_cap_c) begin
            eff_flags_c = (eff_flags_c & ~ex_mask_c) | (ex_val_c & ex_mask_c);
        end
    end

    flag_cond_unit_cond_eval u_cond_eval (
        .flags   (eff_flags_c),
        .ccc     (br_ccc),
        .taken_c (taken_c)
    );

    // Pending/committed flag registers and branch result
    always_ff @(posedge clk) begin
        if (rst) begin
            flags     <= '0;
            pend_v    <= 1'b0;
            pend_mask <= '0;
            pend_val  <= '0;
            br_done   <= 1'b0;
            br_taken  <= 1'b0;
        end else begin
            if (pend_live_c) begin
                flags <= (flags & ~pend_mask) | (pend_val & pend_mask);
            end
            pend_v <= ex_cap_c;
            if (ex_cap_c) begin
                pend_mask <= ex_mask_c;
                pend_val  <= ex_val_c;
            end
            br_done  <= br_valid & ~flush;
            br_taken <= br_valid & ~flush & taken_c;
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
module tb_flag_cond_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [15:0] alu_res;
    logic        alu_ovfl;
    logic        stall;
    logic        flush;
    logic        br_valid;
    logic [2:0]  br_ccc;
    logic [2:0]  flags;
    logic        br_done;
    logic        br_taken;

    int n_total = 0;
    int n_pass  = 0;

    flag_cond_unit dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .ex_op    (ex_op),
        .alu_res  (alu_res),
        .alu_ovfl (alu_ovfl),
        .stall    (stall),
        .flush    (flush),
        .br_valid (br_valid),
        .br_ccc   (br_ccc),
        .flags    (flags),
        .br_done  (br_done),
        .br_taken (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ovfl;
        logic        stall;
        logic        flush;
        logic        brv;
        logic [2:0]  ccc;
        logic [2:0]  ef;
        logic        ed;
        logic        et;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input logic r, input logic v, input logic [3:0] op,
                         input logic [15:0] res, input logic ov, input logic st,
                         input logic fl, input logic bv, input logic [2:0] cc);
        rst      = r;
        ex_valid = v;
        ex_op    = op;
        alu_res  = res;
        alu_ovfl = ov;
        stall    = st;
        flush    = fl;
        br_valid = bv;
        br_ccc   = cc;
    endtask

    task automatic check(input string nm, input logic [2:0] ef, input logic ed, input logic et);
        n_total++;
        if (flags === ef) n_pass++;
        else $display("FAIL %s flags: got %b want %b", nm, flags, ef);
        n_total++;
        if (br_done === ed) n_pass++;
        else $display("FAIL %s br_done: got %b want %b", nm, br_done, ed);
        n_total++;
        if (br_taken === et) n_pass++;
        else $display("FAIL %s br_taken: got %b want %b", nm, br_taken, et);
    endtask

    // Reference: which flags an opcode writes ({Z,V,N})
    function automatic bit [2:0] ref_mask(input bit [3:0] op);
        if (op == 4'd0 || op == 4'd1) return 3'b111;
        if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 3'b100;
        return 3'b000;
    endfunction

    // Reference: branch condition from named flags
    function automatic bit ref_cond(input bit [2:0] cc, input bit z, input bit v, input bit n);
        bit t;
        t = 1'b0;
        case (cc)
            3'd0: t = !z;
            3'd1: t = z;
            3'd2: t = !z && !n;
            3'd3: t = n;
            3'd4: t = z || !n;
            3'd5: t = n || z;
            3'd6: t = v;
            default: t = 1'b1;
        endcase
        return t;
    endfunction

    initial begin
        // valid op res ovfl stall flush brv ccc | flags done taken (after edge)
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b000, 0, 0}); // idle
        vecs.push_back('{1, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b000, 0, 0}); // ADD zero
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b100, 0, 0}); // commit
        vecs.push_back('{1, 4'h1, 16'h8000, 1, 0, 0, 0, 3'd0, 3'b100, 0, 0}); // SUB neg ovfl
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b011, 0, 0});
        vecs.push_back('{1, 4'h0, 16'h0001, 0, 0, 0, 0, 3'd0, 3'b011, 0, 0}); // clear flags
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b000, 0, 0});
        vecs.push_back('{1, 4'h2, 16'h0000, 0, 0, 0, 1, 3'd1, 3'b000, 1, 1}); // XOR + EQ bypass
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b100, 0, 0});
        vecs.push_back('{1, 4'h0, 16'h0005, 0, 0, 0, 0, 3'd0, 3'b100, 0, 0}); // ADD 5
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 1, 0, 3'd0, 3'b100, 0, 0}); // flush squashes
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd0, 3'b100, 1, 0}); // NEQ on old Z
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b100, 0, 0});
        vecs.push_back('{1, 4'h0, 16'h7fff, 1, 0, 0, 0, 3'd0, 3'b100, 0, 0}); // ADD ovfl
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd6, 3'b010, 1, 1}); // OVFL via pend
        vecs.push_back('{1, 4'h0, 16'h0001, 0, 0, 0, 0, 3'd0, 3'b010, 0, 0});
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b000, 0, 0});
        vecs.push_back('{1, 4'h0, 16'h7fff, 1, 0, 0, 0, 3'd0, 3'b000, 0, 0});
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 1, 1, 3'd6, 3'b000, 0, 0}); // flush drops branch
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b000, 0, 0});
        vecs.push_back('{1, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b000, 0, 0});
        vecs.push_back('{1, 4'h1, 16'h8000, 1, 1, 0, 0, 3'd0, 3'b100, 0, 0}); // stall still commits
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b100, 0, 0});
        vecs.push_back('{1, 4'h0, 16'h8000, 1, 0, 0, 0, 3'd0, 3'b100, 0, 0}); // back-to-back #1
        vecs.push_back('{1, 4'h2, 16'h0000, 0, 0, 0, 1, 3'd2, 3'b011, 1, 0}); // #2 + GT bypass
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b111, 0, 0});
        vecs.push_back('{1, 4'h3, 16'h0001, 0, 0, 0, 0, 3'd0, 3'b111, 0, 0}); // RED no write
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 3'b111, 0, 0});
        vecs.push_back('{0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd7, 3'b111, 1, 1}); // unconditional

        drive(1, 0, 4'h0, 16'h0, 0, 0, 0, 0, 3'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 3'b000, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(0, vecs[i].valid, vecs[i].op, vecs[i].res, vecs[i].ovfl,
                  vecs[i].stall, vecs[i].flush, vecs[i].brv, vecs[i].ccc);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ed, vecs[i].et);
        end

        // Reset while an update is pending and a branch is requested
        drive(0, 1, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0);
        @(posedge clk); #1;
        check("pre_rst_cap", 3'b111, 1'b0, 1'b0);
        drive(1, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd7);
        @(posedge clk); #1;
        check("mid_rst", 3'b000, 1'b0, 1'b0);
        drive(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0);
        @(posedge clk); #1;
        check("post_rst1", 3'b000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("post_rst2", 3'b000, 1'b0, 1'b0);

        // Randomized run against the reference model (state is reset-clean here)
        begin
            bit [2:0] m_flags;
            bit       m_pv;
            bit [2:0] m_pm;
            bit [2:0] m_pval;
            m_flags = '0;
            m_pv    = 1'b0;
            m_pm    = '0;
            m_pval  = '0;
            for (int c = 0; c < 3000; c++) begin
                bit        r, v, ov, st, fl, bv, cap, live, ed, et;
                bit [3:0]  op;
                bit [15:0] res;
                bit [2:0]  cc, mk, vals, eff;
                r   = ($urandom_range(0, 49) == 0);
                v   = ($urandom_range(0, 3) != 0);
                op  = 4'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0: res = 16'h0000;
                    1: res = 16'h8000 | 16'($urandom_range(0, 32767));
                    default: res = 16'($urandom);
                endcase
                ov  = 1'($urandom_range(0, 1));
                st  = ($urandom_range(0, 3) == 0);
                fl  = ($urandom_range(0, 5) == 0);
                bv  = ($urandom_range(0, 1) == 1);
                cc  = 3'($urandom_range(0, 7));
                drive(r, v, op, res, ov, st, fl, bv, cc);

                mk   = ref_mask(op);
                vals = {res == 16'h0, ov, res[15]};
                cap  = v && !st && !fl && (mk != 3'b000);
                live = m_pv && !fl;
                eff  = m_flags;
                for (int b = 0; b < 3; b++) begin
                    if (live && m_pm[b]) eff[b] = m_pval[b];
                    if (cap && mk[b])    eff[b] = vals[b];
                end
                if (r) begin
                    m_flags = '0; m_pv = 0; m_pm = '0; m_pval = '0;
                    ed = 0; et = 0;
                end else begin
                    ed = bv && !fl;
                    et = ed && ref_cond(cc, eff[2], eff[1], eff[0]);
                    if (live)
                        for (int b = 0; b < 3; b++)
                            if (m_pm[b]) m_flags[b] = m_pval[b];
                    m_pv = cap;
                    if (cap) begin
                        m_pm   = mk;
                        m_pval = vals;
                    end
                end
                @(posedge clk); #1;
                check($sformatf("rand%0d", c), m_flags, ed, et);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Sits directly downstream of the 16-bit saturating CLA adder and the rest of the EX-stage ALU.
- Captures the ALU result and overflow indication and produces the Z/V/N condition flags.
- Holds the flags in a two-step speculative-then-committed register, so a pipeline flush can squash a flag update not yet committed.
- Resolves conditional branches against the flags, bypassing from in-flight updates, and returns a registered taken/not-taken decision.

Parameters:
- W, 16, ALU result width.
- OPW, 4, opcode field width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX instruction valid this cycle.
- ex_op  in  OPW  EX opcode (ADD=0000, SUB=0001, XOR=0010, RED=0011, SLL=0100, SRA=0101, ROR=0110, PADDSB=0111; others do not write flags).
- alu_res  in  W  saturated ALU result.
- alu_ovfl  in  1  signed overflow flag, generated by the adder stage before saturation.
- stall  in  1  hold EX; no flag capture this cycle.
- flush  in  1  squash the pending update and any EX capture this cycle.
- br_valid  in  1  branch request from decode.
- br_ccc  in  3  condition code.
- flags  out  3  committed {Z,V,N}.
- br_done  out  1  one-cycle pulse; branch resolved.
- br_taken  out  1  decision; valid while br_done=1.

Behaviour:
- Reset (synchronous): flags=3'b000, pend_v=0, pend_mask=0, pend_val=0, br_done=0, br_taken=0. Any in-flight state is discarded on reset mid-operation.
- Write masks:
  - ADD/SUB: mask={Z,V,N}.
  - XOR/SLL/SRA/ROR: mask={Z}.
  - RED/PADDSB and all other opcodes: mask=0.
- Flag values from the EX inputs:
  - Z = (alu_res==0).
  - V = alu_ovfl.
  - N = alu_res[W-1].
- Capture on cycle t: if ex_valid & ~stall & ~flush & mask!=0, then pend_v<=1, pend_mask<=mask, pend_val<=values. Otherwise pend_v<=0.
- Commit on cycle t+1: if pend_v & ~flush, then flags<=(flags & ~pend_mask) | (pend_val & pend_mask). Latency from EX to committed flags is 2 edges.
- Flush in a cycle: the pending update does not commit and the EX capture is dropped. flags keeps its value.
- Stall with pend_v=1: the pending update still commits (it is already past EX). No new capture.
- Effective flags for branch evaluation, built from priority layers, youngest wins per bit:
  1. committed flags;
  2. pend (if pend_v & ~flush);
  3. the current EX capture (if its capture condition holds).
- Conditions (WISC encoding):
  - 000: NEQ, Z=0.
  - 001: EQ, Z=1.
  - 010: GT, Z=0 & N=0.
  - 011: LT, N=1.
  - 100: GTE, Z=1 | N=0.
  - 101: LTE, N=1 | Z=1.
  - 110: OVFL, V=1.
  - 111: unconditional, always taken.
- Branch resolution: if br_valid & ~flush, then next edge br_done<=1 and br_taken<=cond(effective flags). Otherwise br_done<=0 and br_taken<=0. One-cycle latency; there is no backpressure and a new request may be made every cycle.
- flush together with br_valid: the request is dropped (br_done=0 next cycle).
- Two back-to-back flag writers: the second captures while the first commits. Both apply in order; the younger wins on overlapping bits.

Decomposition:
- Shared package: opcode localparams; flag bit indices (Z=2, V=1, N=0); the CCC encodings; a function mapping opcode to write mask.
- One natural sub-module: cond_eval (combinational, flags[2:0] and ccc[2:0] → taken).
- Pend/commit registers and the bypass merge stay in the top module.

Test Plan:
- Reset then idle → flags=000, br_done=0 and br_taken=0 for all cycles.
- ADD with alu_res=16'h0000, ovfl=0 → two edges later flags=100. A following SUB with res=16'h8000, ovfl=1 → flags=011.
- Committed flags=000; XOR with res=16'h0000 issued in the same cycle as br_valid with ccc=001 → br_done=1 and br_taken=1 next cycle (EX bypass). flags=100 only after the commit edge; V and N are unchanged.
- Write ADD res=16'h0005; the next cycle asserts flush → flags stays at its prior value and pend_v=0. A subsequent branch with ccc=000 evaluates against the old Z.
- Branch with ccc=110 while pend holds V=1 and committed V=0 → taken=1. The same branch with flush asserted → br_done=0.
- Reset asserted while pend_v=1 and br_valid=1 → next cycle flags=000, br_done=0, and no commit afterward.
